tx_rx_system: RTL and testbench

- Single-clock transmit/receive link built around an 8-bit counter.
- Transmit half: free-running 8-bit counter; each value is encoded into a 12-bit Hamming(12,8) codeword and registered onto the channel bus `reg_out`.
- Receive half: takes the channel word, optionally corrupted by a per-bit error mask, computes the syndrome, and registers the recovered byte plus a `valid` flag.
- Used as the top-level transmit/receive system block fed by the clock generator.

---
 rtl/tx_rx_system.sv | 108 ++++++++++
 tb/tb_tx_rx_system.sv | 130 +++++++++++++
 2 files changed

// File: rtl/tx_rx_system.sv
// Counter-driven Hamming(12,8) transmit/receive link with a registered channel word.
// Optional single-error correction in the receiver is enabled by defining TX_RX_SEC_EN.
module tx_rx_system #(
  parameter int CNT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ctr_clr,
  input  logic        ctr_en,
  input  logic        conv_en_n,
  input  logic [11:0] err_mask,
  output logic [11:0] reg_out,
  output logic [7:0]  data_out,
  output logic        valid
);

  // Codeword bit p-1 holds Hamming position p; parity at positions 1, 2, 4, 8.
  function automatic logic [11:0] hamming_encode(input logic [7:0] d);
    logic [11:0] cw;
    cw        = 12'h000;
    cw[2]     = d[0];
    cw[6:4]   = d[3:1];
    cw[11:8]  = d[7:4];
    cw[0]     = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    cw[1]     = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    cw[3]     = d[1] ^ d[2] ^ d[3] ^ d[7];
    cw[7]     = d[4] ^ d[5] ^ d[6] ^ d[7];
    return cw;
  endfunction

  function automatic logic [7:0] hamming_data(input logic [11:0] cw);
    return {cw[11:8], cw[6:4], cw[2]};
  endfunction

  function automatic logic [3:0] hamming_syndrome(input logic [11:0] cw);
    logic [11:0] ref_cw;
    ref_cw = hamming_encode(hamming_data(cw));
    return {ref_cw[7] ^ cw[7], ref_cw[3] ^ cw[3], ref_cw[1] ^ cw[1], ref_cw[0] ^ cw[0]};
  endfunction

  logic [7:0]  count_r;
  logic        tx_vld_r;
  logic [11:0] ch_s;
  logic [3:0]  syn_s;
  logic [7:0]  dec_data_s;
  logic        dec_valid_s;
`ifdef TX_RX_SEC_EN
  logic [11:0] fix_s;
`endif

  // Receive path: channel word, syndrome and (optionally corrected) data.
  always_comb begin
    ch_s        = reg_out ^ err_mask;
    syn_s       = hamming_syndrome(ch_s);
    dec_data_s  = hamming_data(ch_s);
    dec_valid_s = (syn_s == 4'd0);
`ifdef TX_RX_SEC_EN
    fix_s = ch_s;
    for (int i = 0; i < 12; i++) begin
      if (syn_s == 4'(i + 1)) begin
        fix_s[i] = ~ch_s[i];
      end else begin
        fix_s[i] = ch_s[i];
      end
    end
    // Syndromes 13..15 point outside the word: leave data raw and flag it.
    if (syn_s <= 4'd12) begin
      dec_data_s  = hamming_data(fix_s);
      dec_valid_s = 1'b1;
    end else begin
      dec_data_s  = hamming_data(ch_s);
      dec_valid_s = 1'b0;
    end
`endif
  end

  // Counter, encoder register and decoder output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r  <= 8'h00;
      tx_vld_r <= 1'b0;
      reg_out  <= 12'h000;
      data_out <= 8'h00;
      valid    <= 1'b0;
    end else begin
      if (ctr_clr) begin
        count_r <= 8'h00;
      end else if (ctr_en) begin
        count_r <= (count_r == 8'(CNT_MAX)) ? 8'h00 : count_r + 8'd1;
      end else begin
        count_r <= count_r;
      end
      // tx_vld_r marks reg_out as freshly encoded, so stale words never decode as valid.
      if (!conv_en_n) begin
        reg_out  <= hamming_encode(count_r);
        tx_vld_r <= 1'b1;
        data_out <= dec_data_s;
        valid    <= dec_valid_s & tx_vld_r;
      end else begin
        reg_out  <= reg_out;
        tx_vld_r <= 1'b0;
        data_out <= data_out;
        valid    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tx_rx_system.sv
// Table-driven bench for tx_rx_system: each row drives inputs for (pre+1) edges and
// checks reg_out/data_out/valid after the last edge against hand-computed values.
module tb_tx_rx_system;

  logic        clk = 1'b0;
  logic        rst, ctr_clr, ctr_en, conv_en_n;
  logic [11:0] err_mask;
  logic [11:0] reg_out;
  logic [7:0]  data_out;
  logic        valid;

  int total = 0;
  int bad   = 0;

`ifdef TX_RX_SEC_EN
  localparam bit SEC = 1'b1;
`else
  localparam bit SEC = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        clr;
    logic        en;
    logic        conv_n;
    logic [11:0] mask;
    int          pre;
    logic [11:0] e_reg;
    logic [7:0]  e_data;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];

  tx_rx_system #(.CNT_MAX(255)) dut (
    .clk(clk), .rst(rst), .ctr_clr(ctr_clr), .ctr_en(ctr_en), .conv_en_n(conv_en_n),
    .err_mask(err_mask), .reg_out(reg_out), .data_out(data_out), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic c, input logic e, input logic cn,
                     input logic [11:0] m, input int pre, input logic [11:0] er,
                     input logic [7:0] ed, input logic ev);
    vec_t v;
    v.rst = r; v.clr = c; v.en = e; v.conv_n = cn; v.mask = m; v.pre = pre;
    v.e_reg = er; v.e_data = ed; v.e_valid = ev;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; ctr_clr = 1'b0; ctr_en = 1'b0; conv_en_n = 1'b1; err_mask = 12'h000;

    //  rst   clr   en    conv  mask     pre  reg      data   valid
    add(1'b1, 1'b0, 1'b0, 1'b1, 12'h000, 0, 12'h000, 8'h00, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1, 12'h000, 0, 12'h000, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 0, 12'h000, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 0, 12'h000, 8'h00, 1'b0);
    // converter on: valid two edges later, then data increments
    add(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 0, 12'h02D, 8'h00, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 0, 12'h033, 8'h05, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 0, 12'h034, 8'h06, 1'b1);
    // hold with ctr_en=0
    add(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 0, 12'h04B, 8'h07, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 0, 12'h04B, 8'h08, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 0, 12'h04B, 8'h08, 1'b1);
    // clear together with enable, then encode 0x00 and 0x01
    add(1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 0, 12'h04B, 8'h08, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 0, 12'h000, 8'h08, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 0, 12'h007, 8'h00, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 0, 12'h007, 8'h01, 1'b1);
    // single-bit error on position 3 while count=0x01
    add(1'b0, 1'b0, 1'b0, 1'b0, 12'h004, 0, 12'h007, SEC ? 8'h01 : 8'h00, SEC);
    add(1'b0, 1'b0, 1'b0, 1'b0, 12'h004, 0, 12'h007, SEC ? 8'h01 : 8'h00, SEC);
    add(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 0, 12'h007, 8'h01, 1'b1);
    // converter disabled mid-stream: freeze, valid low, then re-enable
    add(1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 0, 12'h007, 8'h01, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 0, 12'h007, 8'h01, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 0, 12'h01E, 8'h01, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 0, 12'h02A, 8'h03, 1'b1);
    // syndrome 13 (parity positions 1,4,8): never valid; then parity-bit error
    add(1'b0, 1'b0, 1'b0, 1'b0, 12'h089, 0, 12'h02D, 8'h04, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 12'h001, 0, 12'h02D, 8'h05, SEC);
    add(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 0, 12'h02D, 8'h05, 1'b1);
    // count up to 0xFD with converter off, then watch the wrap
    add(1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 247, 12'h02D, 8'h05, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 0, 12'hF6E, 8'h05, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 0, 12'hF70, 8'hFD, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 0, 12'hF77, 8'hFE, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 0, 12'h000, 8'hFF, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 0, 12'h007, 8'h00, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 0, 12'h019, 8'h01, 1'b1);
    // run to count 0x40, then reset mid-stream and resume from 0
    add(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 60, 12'h37C, 8'h3E, 1'b1);
    add(1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 0, 12'h000, 8'h00, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 0, 12'h000, 8'h00, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 0, 12'h007, 8'h00, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 0, 12'h019, 8'h01, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      rst       = vecs[i].rst;
      ctr_clr   = vecs[i].clr;
      ctr_en    = vecs[i].en;
      conv_en_n = vecs[i].conv_n;
      err_mask  = vecs[i].mask;
      repeat (vecs[i].pre) @(posedge clk);
      @(posedge clk);
      #1;
      total++;
      if (reg_out !== vecs[i].e_reg) begin
        bad++;
        $display("FAIL reg_out row %0d: got %03h want %03h", i, reg_out, vecs[i].e_reg);
      end
      total++;
      if (data_out !== vecs[i].e_data) begin
        bad++;
        $display("FAIL data_out row %0d: got %02h want %02h", i, data_out, vecs[i].e_data);
      end
      total++;
      if (valid !== vecs[i].e_valid) begin
        bad++;
        $display("FAIL valid row %0d: got %0b want %0b", i, valid, vecs[i].e_valid);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
